ahb_lite_arbiter_2m: RTL and testbench
======================================

// Module: ahb_lite_arbiter_2m
// PURPOSE
//  Two-master AHB-Lite arbiter/interconnect input stage in front of one AHB-Lite slave (memory slave).
//  Round-robin address-phase arbitration; a losing master's transfer is held in a per-master register and reissued when granted.
//  Routes slave HREADYOUT/HRESP/HRDATA to the data-phase owner; honours HMASTLOCK and burst continuity.
// PARAMETERS
//  ADDR_WIDTH  32  address width (HADDR, S_HADDR)
//  DATA_WIDTH  32  data bus width (HWDATA/HRDATA)
// PORTS
//  HCLK             in   1    bus clock
//  HRESET           in   1    reset, asynchronous, active-high
//  Mx_HTRANS        in   2    master x (x=0,1) transfer type
//  Mx_HADDR         in   AW   master x address
//  Mx_HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK  in  1/3/3/4/1  master x control
//  Mx_HWDATA        in   DW   master x write data (data phase)
//  Mx_HREADY        out  1    ready to master x
//  Mx_HRESP         out  1    response to master x (0 OKAY, 1 ERROR)
//  Mx_HRDATA        out  DW   read data to master x
//  S_HSEL           out  1    slave select
//  S_HADDR          out  AW   muxed address
//  S_HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK   out  1/3/3/4/1  muxed control
//  S_HTRANS         out  2    muxed transfer type
//  S_HREADY         out  1    = S_HREADYOUT (bus ready fed back to slave)
//  S_HWDATA         out  DW   write data of data-phase owner
//  S_HREADYOUT      in   1    slave ready
//  S_HRESP          in   1    slave response
//  S_HRDATA         in   DW   slave read data
// BEHAVIOUR
//  One clock; reset is asynchronous and active-high. HRESET=1: pending0/1=0, addr_owner=0, data_owner=none, last_grant=1.
//  Reset outputs: Mx_HREADY=1, Mx_HRESP=OKAY, S_HTRANS=IDLE, S_HSEL=0; in-flight/held transfers discarded.
//  Request x: pending_x=1, or (Mx_HTRANS is NONSEQ/SEQ and Mx_HREADY=1). Address taken from hold reg when pending, else live.
//  Arbitration evaluated only in cycles with S_HREADYOUT=1:
//   - current addr_owner keeps grant if its HMASTLOCK=1 or its next HTRANS is SEQ/BUSY (burst in progress);
//   - else one requester -> it; both -> the one != last_grant; none -> S_HTRANS=IDLE, S_HSEL=0, owner unchanged.
//  Granted request drives S_* combinationally (zero added latency); S_HSEL=1 when S_HTRANS!=IDLE.
//  Losing live request: address/control latched into hold_x at clock edge, pending_x=1.
//  Mx_HREADY: data_owner=x -> S_HREADYOUT; pending_x=1 or held transfer in data phase -> 0; else 1.
//  pending_x clears on the edge its held transfer is issued with S_HREADYOUT=1; data_owner<=x same edge.
//  S_HWDATA = Mx_HWDATA of data_owner (master holds data stable while its HREADY=0).
//  Mx_HRESP = S_HRESP when data_owner=x, else OKAY; two-cycle ERROR passes through unchanged.
//  Mx_HRDATA = S_HRDATA for both (only owner samples it).
//  BUSY/IDLE from non-owner never forwarded; IDLE from owner while other pending -> grant switches.
//  Grant never changes while S_HREADYOUT=0 (wait states freeze owner, hold regs, S_* outputs).
//  Reset asserted mid-transfer: all state cleared asynchronously, no partial write reissued.
// TESTING
//  1 M0 NONSEQ write 0x10 word, M1 idle -> S_HADDR=0x10 same cycle, M0_HREADY follows S_HREADYOUT, M1_HREADY=1.
//  2 M0,M1 NONSEQ same cycle (0x20,0x40) after reset -> M0 issued first, M1 held (M1_HREADY=0), 0x40 issued next cycle.
//  3 Repeat contention -> M1 wins (round-robin), M0 held; order alternates over 4 contentions.
//  4 M0 HMASTLOCK=1 INCR4 from 0x00, M1 NONSEQ in beat 2 -> all 4 M0 beats uninterrupted, then M1.
//  5 Slave ERROR (addr 0x3FE word) for M1 -> M1_HRESP=1 for 2 cycles, M1_HREADY 0 then 1, M0_HRESP=0.
//  6 HRESET=1 while M1 pending during slave wait -> outputs to reset values immediately, no M1 transfer issued.

Source files
------------

// File: rtl/ahb_lite_arbiter_2m_if.sv
// Signal bundle joining two AHB-Lite masters, the two-master arbiter and one AHB-Lite slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ahb_lite_arbiter_2m_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            M0_HTRANS;
  logic [ADDR_WIDTH-1:0] M0_HADDR;
  logic                  M0_HWRITE;
  logic [2:0]            M0_HSIZE;
  logic [2:0]            M0_HBURST;
  logic [3:0]            M0_HPROT;
  logic                  M0_HMASTLOCK;
  logic [DATA_WIDTH-1:0] M0_HWDATA;
  logic                  M0_HREADY;
  logic                  M0_HRESP;
  logic [DATA_WIDTH-1:0] M0_HRDATA;

  logic [1:0]            M1_HTRANS;
  logic [ADDR_WIDTH-1:0] M1_HADDR;
  logic                  M1_HWRITE;
  logic [2:0]            M1_HSIZE;
  logic [2:0]            M1_HBURST;
  logic [3:0]            M1_HPROT;
  logic                  M1_HMASTLOCK;
  logic [DATA_WIDTH-1:0] M1_HWDATA;
  logic                  M1_HREADY;
  logic                  M1_HRESP;
  logic [DATA_WIDTH-1:0] M1_HRDATA;

  logic                  S_HSEL;
  logic [ADDR_WIDTH-1:0] S_HADDR;
  logic                  S_HWRITE;
  logic [2:0]            S_HSIZE;
  logic [2:0]            S_HBURST;
  logic [3:0]            S_HPROT;
  logic                  S_HMASTLOCK;
  logic [1:0]            S_HTRANS;
  logic                  S_HREADY;
  logic [DATA_WIDTH-1:0] S_HWDATA;
  logic                  S_HREADYOUT;
  logic                  S_HRESP;
  logic [DATA_WIDTH-1:0] S_HRDATA;

  modport slave (
    input  M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK, M0_HWDATA,
    input  M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK, M1_HWDATA,
    output M0_HREADY, M0_HRESP, M0_HRDATA, M1_HREADY, M1_HRESP, M1_HRDATA,
    output S_HSEL, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HTRANS,
    output S_HREADY, S_HWDATA,
    input  S_HREADYOUT, S_HRESP, S_HRDATA
  );

  modport master (
    output M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HBURST, M0_HPROT, M0_HMASTLOCK, M0_HWDATA,
    output M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HBURST, M1_HPROT, M1_HMASTLOCK, M1_HWDATA,
    input  M0_HREADY, M0_HRESP, M0_HRDATA, M1_HREADY, M1_HRESP, M1_HRDATA,
    input  S_HSEL, S_HADDR, S_HWRITE, S_HSIZE, S_HBURST, S_HPROT, S_HMASTLOCK, S_HTRANS,
    input  S_HREADY, S_HWDATA,
    output S_HREADYOUT, S_HRESP, S_HRDATA
  );
endinterface

// File: rtl/ahb_lite_arbiter_2m.sv
// Two-master AHB-Lite arbiter in front of a single slave: round-robin address-phase arbitration,
// a hold register per master for a transfer that lost, and response routing to the data-phase owner.
module ahb_lite_arbiter_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                  HCLK,
  input logic                  HRESET,
  ahb_lite_arbiter_2m_if.slave bus
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

  typedef struct packed {
    logic [1:0]            trans;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  write;
    logic [2:0]            size;
    logic [2:0]            burst;
    logic [3:0]            prot;
    logic                  lock;
  } xfer_t;

  xfer_t                 hold [2];
  xfer_t                 live [2];
  xfer_t                 view [2];
  xfer_t                 s_xfer;
  logic [1:0]            pending;
  logic [1:0]            hready;
  logic [1:0]            req;
  logic [1:0]            taken;
  logic                  addr_owner;
  logic                  last_grant;
  owner_t                data_owner;
  logic                  keep;
  logic                  grant;
  logic                  s_valid;
  logic                  s_issue;
  logic                  contend;
  logic [DATA_WIDTH-1:0] wdata_mux;

  // A master sees its transfer as taken whenever it drives NONSEQ/SEQ with HREADY high,
  // so anything it drives while not being issued must be captured into its hold register.
  always_comb begin
    live[0] = {bus.M0_HTRANS, bus.M0_HADDR, bus.M0_HWRITE, bus.M0_HSIZE,
               bus.M0_HBURST, bus.M0_HPROT, bus.M0_HMASTLOCK};
    live[1] = {bus.M1_HTRANS, bus.M1_HADDR, bus.M1_HWRITE, bus.M1_HSIZE,
               bus.M1_HBURST, bus.M1_HPROT, bus.M1_HMASTLOCK};
    hready[0] = (data_owner == OWN_M0) ? bus.S_HREADYOUT : ~pending[0];
    hready[1] = (data_owner == OWN_M1) ? bus.S_HREADYOUT : ~pending[1];
    for (int i = 0; i < 2; i++) begin
      view[i]  = pending[i] ? hold[i] : live[i];
      req[i]   = pending[i] | (live[i].trans[1] & hready[i]);
      taken[i] = live[i].trans[1] & hready[i] & ~pending[i];
    end

    keep    = view[addr_owner].lock | view[addr_owner].trans[0];
    grant   = addr_owner;
    s_valid = 1'b0;
    contend = 1'b0;
    if (!bus.S_HREADYOUT || keep) begin
      s_valid = (view[addr_owner].trans != HTRANS_IDLE);
    end else if (req == 2'b11) begin
      grant   = ~last_grant;
      s_valid = 1'b1;
      contend = 1'b1;
    end else if (req[0]) begin
      grant   = 1'b0;
      s_valid = 1'b1;
    end else if (req[1]) begin
      grant   = 1'b1;
      s_valid = 1'b1;
    end

    s_xfer    = view[grant];
    s_issue   = bus.S_HREADYOUT & s_valid & s_xfer.trans[1];
    wdata_mux = (data_owner == OWN_M1) ? bus.M1_HWDATA : bus.M0_HWDATA;
  end

  // The round-robin pointer moves only on a genuine two-way decision, so back-to-back
  // contentions alternate no matter how many uncontested grants fall in between.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pending    <= 2'b00;
      hold[0]    <= '0;
      hold[1]    <= '0;
      addr_owner <= 1'b0;
      last_grant <= 1'b1;
      data_owner <= OWN_NONE;
    end else begin
      if (bus.S_HREADYOUT) begin
        addr_owner <= grant;
        data_owner <= s_issue ? (grant ? OWN_M1 : OWN_M0) : OWN_NONE;
        if (contend) begin
          last_grant <= grant;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (s_issue && grant == 1'(i)) begin
          pending[i] <= 1'b0;
        end else if (taken[i]) begin
          pending[i] <= 1'b1;
          hold[i]    <= live[i];
        end
      end
    end
  end

  assign bus.S_HTRANS    = (s_valid && !HRESET) ? s_xfer.trans : HTRANS_IDLE;
  assign bus.S_HSEL      = s_valid && !HRESET;
  assign bus.S_HADDR     = s_xfer.addr;
  assign bus.S_HWRITE    = s_xfer.write;
  assign bus.S_HSIZE     = s_xfer.size;
  assign bus.S_HBURST    = s_xfer.burst;
  assign bus.S_HPROT     = s_xfer.prot;
  assign bus.S_HMASTLOCK = s_xfer.lock;
  assign bus.S_HREADY    = bus.S_HREADYOUT;
  assign bus.S_HWDATA    = wdata_mux;

  assign bus.M0_HREADY = hready[0];
  assign bus.M1_HREADY = hready[1];
  assign bus.M0_HRESP  = (data_owner == OWN_M0) ? bus.S_HRESP : 1'b0;
  assign bus.M1_HRESP  = (data_owner == OWN_M1) ? bus.S_HRESP : 1'b0;
  assign bus.M0_HRDATA = bus.S_HRDATA;
  assign bus.M1_HRDATA = bus.S_HRDATA;

endmodule

// File: tb/tb_ahb_lite_arbiter_2m.sv
// Directed bench for the two-master AHB-Lite arbiter: masters and slave responses are driven
// cycle by cycle from hand-computed vectors and every observation goes through checkOutput.
module tb_ahb_lite_arbiter_2m;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  int   assert_count = 0;
  int   fail_count = 0;
  int   exp_win [3] = '{1, 0, 1};

  ahb_lite_arbiter_2m_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ahb_lite_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus.slave)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m0_trans, input logic [31:0] m0_addr, input logic m0_lock,
                               input logic [1:0] m1_trans, input logic [31:0] m1_addr,
                               input logic s_ready, input logic s_resp);
    bus.M0_HTRANS    = m0_trans;
    bus.M0_HADDR     = m0_addr;
    bus.M0_HWRITE    = 1'b1;
    bus.M0_HSIZE     = 3'b010;
    bus.M0_HBURST    = m0_lock ? 3'b011 : 3'b000;
    bus.M0_HPROT     = 4'b0011;
    bus.M0_HMASTLOCK = m0_lock;
    bus.M1_HTRANS    = m1_trans;
    bus.M1_HADDR     = m1_addr;
    bus.M1_HWRITE    = 1'b1;
    bus.M1_HSIZE     = 3'b010;
    bus.M1_HBURST    = 3'b000;
    bus.M1_HPROT     = 4'b0011;
    bus.M1_HMASTLOCK = 1'b0;
    bus.S_HREADYOUT  = s_ready;
    bus.S_HRESP      = s_resp;
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    bus.M0_HWDATA = 32'hA0A0_0000;
    bus.M1_HWDATA = 32'hB1B1_0000;
    bus.S_HRDATA  = 32'h5A5A_C3C3;
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);

    @(negedge HCLK);
    checkOutput("rst_m0_hready", bus.M0_HREADY, 1'b1);
    checkOutput("rst_m1_hready", bus.M1_HREADY, 1'b1);
    checkOutput("rst_htrans",    bus.S_HTRANS, IDLE);
    checkOutput("rst_hsel",      bus.S_HSEL, 1'b0);
    checkOutput("rst_m1_hresp",  bus.M1_HRESP, 1'b0);
    next_cycle();
    HRESET = 1'b0;

    // Single master, one wait state in its data phase
    next_cycle();
    applyStimulus(NONSEQ, 32'h10, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t1_haddr",  bus.S_HADDR, 32'h10);
    checkOutput("t1_htrans", bus.S_HTRANS, NONSEQ);
    checkOutput("t1_hsel",   bus.S_HSEL, 1'b1);
    checkOutput("t1_m1_rdy", bus.M1_HREADY, 1'b1);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checkOutput("t1_m0_wait",   bus.M0_HREADY, 1'b0);
    checkOutput("t1_m1_rdy_w",  bus.M1_HREADY, 1'b1);
    checkOutput("t1_hwdata",    bus.S_HWDATA, 32'hA0A0_0000);
    checkOutput("t1_idle",      bus.S_HTRANS, IDLE);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t1_m0_done", bus.M0_HREADY, 1'b1);

    // First contention after reset goes to M0, M1 is held and reissued
    next_cycle();
    applyStimulus(NONSEQ, 32'h20, 1'b0, NONSEQ, 32'h40, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t2_first_addr", bus.S_HADDR, 32'h20);
    checkOutput("t2_m1_rdy",     bus.M1_HREADY, 1'b1);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t2_second_addr",  bus.S_HADDR, 32'h40);
    checkOutput("t2_second_trans", bus.S_HTRANS, NONSEQ);
    checkOutput("t2_m1_held",      bus.M1_HREADY, 1'b0);
    checkOutput("t2_m0_rdy",       bus.M0_HREADY, 1'b1);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t2_m1_dphase", bus.M1_HREADY, 1'b1);
    checkOutput("t2_hwdata",    bus.S_HWDATA, 32'hB1B1_0000);
    checkOutput("t2_idle",      bus.S_HTRANS, IDLE);

    // Contentions two to four alternate M1, M0, M1
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      applyStimulus(NONSEQ, 32'h100 + 32'(16 * k), 1'b0, NONSEQ, 32'h200 + 32'(16 * k), 1'b1, 1'b0);
      @(negedge HCLK);
      checkOutput($sformatf("t3_win_addr%0d", k), bus.S_HADDR,
                  (exp_win[k] == 1) ? 32'h200 + 32'(16 * k) : 32'h100 + 32'(16 * k));
      next_cycle();
      applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
      @(negedge HCLK);
      checkOutput($sformatf("t3_lose_addr%0d", k), bus.S_HADDR,
                  (exp_win[k] == 1) ? 32'h100 + 32'(16 * k) : 32'h200 + 32'(16 * k));
      checkOutput($sformatf("t3_hready%0d", k), {bus.M0_HREADY, bus.M1_HREADY},
                  (exp_win[k] == 1) ? 2'b01 : 2'b10);
      next_cycle();
      applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    end

    // Locked INCR4 from M0 is not broken by an M1 request in beat 2
    next_cycle();
    applyStimulus(NONSEQ, 32'h00, 1'b1, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t4_b0_addr",  bus.S_HADDR, 32'h00);
    checkOutput("t4_b0_trans", bus.S_HTRANS, NONSEQ);
    checkOutput("t4_lock",     bus.S_HMASTLOCK, 1'b1);
    checkOutput("t4_burst",    bus.S_HBURST, 3'b011);
    next_cycle();
    applyStimulus(SEQ, 32'h04, 1'b1, NONSEQ, 32'h80, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t4_b1_addr", bus.S_HADDR, 32'h04);
    checkOutput("t4_m1_rdy",  bus.M1_HREADY, 1'b1);
    next_cycle();
    applyStimulus(SEQ, 32'h08, 1'b1, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t4_b2_addr", bus.S_HADDR, 32'h08);
    checkOutput("t4_m1_held", bus.M1_HREADY, 1'b0);
    next_cycle();
    applyStimulus(SEQ, 32'h0C, 1'b1, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t4_b3_addr",  bus.S_HADDR, 32'h0C);
    checkOutput("t4_b3_trans", bus.S_HTRANS, SEQ);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t4_m1_addr",  bus.S_HADDR, 32'h80);
    checkOutput("t4_m1_trans", bus.S_HTRANS, NONSEQ);
    checkOutput("t4_unlock",   bus.S_HMASTLOCK, 1'b0);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);

    // Two-cycle ERROR response routed to M1 only
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, NONSEQ, 32'h3FE, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t5_addr", bus.S_HADDR, 32'h3FE);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b1);
    @(negedge HCLK);
    checkOutput("t5_resp1",    bus.M1_HRESP, 1'b1);
    checkOutput("t5_ready1",   bus.M1_HREADY, 1'b0);
    checkOutput("t5_m0_resp1", bus.M0_HRESP, 1'b0);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b1);
    @(negedge HCLK);
    checkOutput("t5_resp2",    bus.M1_HRESP, 1'b1);
    checkOutput("t5_ready2",   bus.M1_HREADY, 1'b1);
    checkOutput("t5_m0_resp2", bus.M0_HRESP, 1'b0);
    checkOutput("t5_rdata",    bus.M1_HRDATA, 32'h5A5A_C3C3);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);

    // Reset while M1 is held behind a stalled M0 data phase
    next_cycle();
    applyStimulus(NONSEQ, 32'h500, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t6_addr", bus.S_HADDR, 32'h500);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, NONSEQ, 32'h600, 1'b0, 1'b0);
    @(negedge HCLK);
    checkOutput("t6_wait_htrans", bus.S_HTRANS, IDLE);
    checkOutput("t6_m1_rdy",      bus.M1_HREADY, 1'b1);
    checkOutput("t6_m0_wait",     bus.M0_HREADY, 1'b0);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checkOutput("t6_m1_pending", bus.M1_HREADY, 1'b0);
    #1;
    HRESET = 1'b1;
    #1;
    checkOutput("t6_rst_m1_rdy", bus.M1_HREADY, 1'b1);
    checkOutput("t6_rst_m0_rdy", bus.M0_HREADY, 1'b1);
    checkOutput("t6_rst_htrans", bus.S_HTRANS, IDLE);
    checkOutput("t6_rst_hsel",   bus.S_HSEL, 1'b0);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    next_cycle();
    HRESET = 1'b0;
    @(negedge HCLK);
    checkOutput("t6_no_reissue", bus.S_HTRANS, IDLE);
    checkOutput("t6_m1_free",    bus.M1_HREADY, 1'b1);
    next_cycle();
    applyStimulus(NONSEQ, 32'h700, 1'b0, NONSEQ, 32'h800, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t6_rr_reset_m0", bus.S_HADDR, 32'h700);
    next_cycle();
    applyStimulus(IDLE, 32'h0, 1'b0, IDLE, 32'h0, 1'b1, 1'b0);
    @(negedge HCLK);
    checkOutput("t6_rr_reset_m1", bus.S_HADDR, 32'h800);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
